// File: rtl/cpu_fsm_control_pkg.sv
// ---------------------------------------------------------------------------
// cpu_fsm_control_pkg
// Shared codes for the multicycle MIPS control unit: state encoding,
// datapath select encodings, ALU operation codes, opcode/function constants
// and the decoded control bundle passed from cpu_fsm_control_decode to
// cpu_fsm_control.
// Optional feature macro: CPU_CONTROL_MULTDIV_EN adds the HI/LO and
// multiply/divide fields to the control bundle.
// ---------------------------------------------------------------------------
package cpu_fsm_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_EXEC1  = 3'd1,
        ST_EXEC2  = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_PASS_B = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        SRCB_RT   = 2'd0,
        SRCB_SEXT = 2'd1,
        SRCB_ZEXT = 2'd2,
        SRCB_LUI  = 2'd3
    } src_b_sel_t;

    typedef enum logic [1:0] {
        WD_RAM  = 2'd0,
        WD_ALU  = 2'd1,
        WD_PC8  = 2'd2,
        WD_HILO = 2'd3
    } wd_sel_t;

    typedef enum logic [1:0] {
        A3_RT  = 2'd0,
        A3_RD  = 2'd1,
        A3_R31 = 2'd2
    } a3_sel_t;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_JALR  = 6'h09;
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_XOR   = 6'h26;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

    // Decoded control bundle; valid whenever the IR fields are stable.
    typedef struct packed {
        logic       illegal;
        logic       is_load;
        logic       is_store;
        logic       is_beq;
        logic       is_bne;
        logic       is_jump;
        logic       reg_wen;
        a3_sel_t    a3_sel;
        wd_sel_t    wd_sel;
        src_b_sel_t src_b_sel;
        alu_op_t    alu_op;
`ifdef CPU_CONTROL_MULTDIV_EN
        logic       md_start;
        logic       hilo_wen;
        logic       hilo_rd_sel;
        logic       mf;
`endif
    } ctrl_t;

    // All-zero bundle: no side effects, selects at their first encoding.
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c = {$bits(ctrl_t){1'b0}};
        return c;
    endfunction

endpackage

// File: rtl/cpu_fsm_control_decode.sv
// ---------------------------------------------------------------------------
// cpu_fsm_control_decode
// Purely combinational instruction decoder: opcode/function fields from the
// instruction register to the control bundle, plus an illegal flag for any
// unsupported encoding.
// Ports:
//   opcode_i   - instruction opcode
//   function_i - SPECIAL function field
//   ctrl_o     - decoded control bundle (ctrl_t), including illegal flag
// Optional feature macro: CPU_CONTROL_MULTDIV_EN decodes MULT/MULTU/DIV/DIVU,
// MFHI/MFLO and MTHI/MTLO; without it these functions are illegal.
// ---------------------------------------------------------------------------
module cpu_fsm_control_decode
    import cpu_fsm_control_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] function_i,
    output ctrl_t      ctrl_o
);

    ctrl_t ctrl_s;

    // Opcode/function to control bundle.
    always_comb begin
        ctrl_s = ctrl_default();
        case (opcode_i)
            OP_SPECIAL: begin
                ctrl_s.a3_sel = A3_RD;
                ctrl_s.wd_sel = WD_ALU;
                case (function_i)
                    FUNC_ADDU: begin ctrl_s.reg_wen = 1'b1; ctrl_s.alu_op = ALU_ADD;  end
                    FUNC_SUBU: begin ctrl_s.reg_wen = 1'b1; ctrl_s.alu_op = ALU_SUB;  end
                    FUNC_AND:  begin ctrl_s.reg_wen = 1'b1; ctrl_s.alu_op = ALU_AND;  end
                    FUNC_OR:   begin ctrl_s.reg_wen = 1'b1; ctrl_s.alu_op = ALU_OR;   end
                    FUNC_XOR:  begin ctrl_s.reg_wen = 1'b1; ctrl_s.alu_op = ALU_XOR;  end
                    FUNC_SLT:  begin ctrl_s.reg_wen = 1'b1; ctrl_s.alu_op = ALU_SLT;  end
                    FUNC_SLTU: begin ctrl_s.reg_wen = 1'b1; ctrl_s.alu_op = ALU_SLTU; end
                    FUNC_JR: begin
                        ctrl_s.is_jump = 1'b1;
                    end
                    FUNC_JALR: begin
                        ctrl_s.is_jump = 1'b1;
                        ctrl_s.reg_wen = 1'b1;
                        ctrl_s.wd_sel  = WD_PC8;
                    end
`ifdef CPU_CONTROL_MULTDIV_EN
                    FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
                        ctrl_s.md_start = 1'b1;
                    end
                    FUNC_MFHI: begin
                        ctrl_s.mf          = 1'b1;
                        ctrl_s.reg_wen     = 1'b1;
                        ctrl_s.wd_sel      = WD_HILO;
                        ctrl_s.hilo_rd_sel = 1'b1;
                    end
                    FUNC_MFLO: begin
                        ctrl_s.mf      = 1'b1;
                        ctrl_s.reg_wen = 1'b1;
                        ctrl_s.wd_sel  = WD_HILO;
                    end
                    FUNC_MTHI: begin
                        ctrl_s.hilo_wen    = 1'b1;
                        ctrl_s.hilo_rd_sel = 1'b1;
                    end
                    FUNC_MTLO: begin
                        ctrl_s.hilo_wen = 1'b1;
                    end
`endif
                    default: ctrl_s.illegal = 1'b1;
                endcase
            end
            OP_J: begin
                ctrl_s.is_jump = 1'b1;
            end
            OP_JAL: begin
                ctrl_s.is_jump = 1'b1;
                ctrl_s.reg_wen = 1'b1;
                ctrl_s.a3_sel  = A3_R31;
                ctrl_s.wd_sel  = WD_PC8;
            end
            OP_BEQ: begin
                ctrl_s.is_beq = 1'b1;
                ctrl_s.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                ctrl_s.is_bne = 1'b1;
                ctrl_s.alu_op = ALU_SUB;
            end
            OP_ADDIU: begin
                ctrl_s.reg_wen   = 1'b1;
                ctrl_s.wd_sel    = WD_ALU;
                ctrl_s.src_b_sel = SRCB_SEXT;
                ctrl_s.alu_op    = ALU_ADD;
            end
            OP_ANDI: begin
                ctrl_s.reg_wen   = 1'b1;
                ctrl_s.wd_sel    = WD_ALU;
                ctrl_s.src_b_sel = SRCB_ZEXT;
                ctrl_s.alu_op    = ALU_AND;
            end
            OP_ORI: begin
                ctrl_s.reg_wen   = 1'b1;
                ctrl_s.wd_sel    = WD_ALU;
                ctrl_s.src_b_sel = SRCB_ZEXT;
                ctrl_s.alu_op    = ALU_OR;
            end
            OP_XORI: begin
                ctrl_s.reg_wen   = 1'b1;
                ctrl_s.wd_sel    = WD_ALU;
                ctrl_s.src_b_sel = SRCB_ZEXT;
                ctrl_s.alu_op    = ALU_XOR;
            end
            OP_LUI: begin
                ctrl_s.reg_wen   = 1'b1;
                ctrl_s.wd_sel    = WD_ALU;
                ctrl_s.src_b_sel = SRCB_LUI;
                ctrl_s.alu_op    = ALU_PASS_B;
            end
            OP_LW: begin
                ctrl_s.is_load   = 1'b1;
                ctrl_s.reg_wen   = 1'b1;
                ctrl_s.wd_sel    = WD_RAM;
                ctrl_s.src_b_sel = SRCB_SEXT;
                ctrl_s.alu_op    = ALU_ADD;
            end
            OP_SW: begin
                ctrl_s.is_store  = 1'b1;
                ctrl_s.src_b_sel = SRCB_SEXT;
                ctrl_s.alu_op    = ALU_ADD;
            end
            default: ctrl_s.illegal = 1'b1;
        endcase
    end

    assign ctrl_o = ctrl_s;

endmodule

// File: rtl/cpu_fsm_control.sv
// ---------------------------------------------------------------------------
// cpu_fsm_control
// Multicycle MIPS control unit. Owns the FETCH/EXEC1/EXEC2 state register,
// stretches states while memory asserts waitrequest, tracks the branch/jump
// delay slot with a pending-branch flag, and parks in HALTED (jump to 0) or
// FAULT (illegal instruction or wait timeout) until reset.
// Ports:
//   clk_i, rst_ni              - clock, synchronous active-low reset
//   waitrequest_i              - memory not ready, hold current access
//   opcode_i, function_i       - IR decode fields
//   alu_zero_i, jump_to_zero_i - branch condition / halt detection
//   state_o, active_o, fault_o - status
//   *_wen_o, ram_rds_o, *_sel_o, tgt_wen_o, alu_op_o - datapath controls
//                                (combinational from state and decode)
// Optional feature macro: CPU_CONTROL_MULTDIV_EN adds md_busy_i, md_start_o,
// hilo_wen_o and hilo_rd_sel_o.
// ---------------------------------------------------------------------------
module cpu_fsm_control
    import cpu_fsm_control_pkg::*;
#(
    parameter int ALU_OP_W     = 4,
    parameter int WAIT_TIMEOUT = 0,
    parameter int TIMEOUT_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                waitrequest_i,
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          function_i,
    input  logic                alu_zero_i,
    input  logic                jump_to_zero_i,
`ifdef CPU_CONTROL_MULTDIV_EN
    input  logic                md_busy_i,
    output logic                md_start_o,
    output logic                hilo_wen_o,
    output logic                hilo_rd_sel_o,
`endif
    output logic [2:0]          state_o,
    output logic                active_o,
    output logic                fault_o,
    output logic                pc_wen_o,
    output logic                ir_wen_o,
    output logic                ram_wen_o,
    output logic                ram_rds_o,
    output logic                reg_wen_o,
    output logic                ram_a_sel_o,
    output logic [1:0]          src_b_sel_o,
    output logic [1:0]          reg_wd_sel_o,
    output logic [1:0]          reg_a3_sel_o,
    output logic [1:0]          pc_sel_o,
    output logic                tgt_wen_o,
    output logic [ALU_OP_W-1:0] alu_op_o
);

    localparam bit TIMEOUT_EN = (WAIT_TIMEOUT > 0);
    // Counter value seen during the last permitted stall cycle.
    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT =
        TIMEOUT_EN ? TIMEOUT_W'(WAIT_TIMEOUT - 1) : {TIMEOUT_W{1'b0}};

    state_t                state_q, state_d;
    logic                  branch_pending_q, branch_pending_d;
    pc_sel_t               pend_sel_q, pend_sel_d;
    logic [TIMEOUT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                  fault_q, fault_d;
    logic                  active_q, active_d;

    ctrl_t                 ctrl_s;
    logic                  is_mem_s;
    logic                  stall_s;
    logic                  timeout_s;
    logic                  taken_s;
    logic                  mf_stall_s;

    logic                  pc_wen_s, ir_wen_s, ram_wen_s, ram_rds_s, reg_wen_s;
    logic                  ram_a_sel_s, tgt_wen_s;
    src_b_sel_t            src_b_sel_s;
    wd_sel_t               wd_sel_s;
    a3_sel_t               a3_sel_s;
    pc_sel_t               pc_sel_s;
    alu_op_t               alu_op_s;
`ifdef CPU_CONTROL_MULTDIV_EN
    logic                  md_start_s, hilo_wen_s, hilo_rd_sel_s;
`endif

    cpu_fsm_control_decode u_decode (
        .opcode_i   (opcode_i),
        .function_i (function_i),
        .ctrl_o     (ctrl_s)
    );

    assign is_mem_s = ctrl_s.is_load | ctrl_s.is_store;

    // A stall is a cycle in which the memory access must be held.
    assign stall_s = waitrequest_i &
                     ((state_q == ST_FETCH) | ((state_q == ST_EXEC1) & is_mem_s));

    assign timeout_s = TIMEOUT_EN & stall_s & (wait_cnt_q == WAIT_LIMIT);

    assign taken_s = (ctrl_s.is_beq & alu_zero_i) |
                     (ctrl_s.is_bne & ~alu_zero_i) |
                     ctrl_s.is_jump;

`ifdef CPU_CONTROL_MULTDIV_EN
    assign mf_stall_s = ctrl_s.mf & md_busy_i;
`else
    assign mf_stall_s = 1'b0;
`endif

    // Next-state logic and combinational datapath controls.
    always_comb begin
        state_d          = state_q;
        branch_pending_d = branch_pending_q;
        pend_sel_d       = pend_sel_q;
        fault_d          = fault_q;
        active_d         = active_q;
        pc_wen_s         = 1'b0;
        ir_wen_s         = 1'b0;
        ram_wen_s        = 1'b0;
        ram_rds_s        = 1'b0;
        reg_wen_s        = 1'b0;
        ram_a_sel_s      = 1'b0;
        tgt_wen_s        = 1'b0;
        src_b_sel_s      = SRCB_RT;
        wd_sel_s         = WD_RAM;
        a3_sel_s         = A3_RT;
        pc_sel_s         = PC_PLUS4;
        alu_op_s         = ALU_ADD;
`ifdef CPU_CONTROL_MULTDIV_EN
        md_start_s       = 1'b0;
        hilo_wen_s       = 1'b0;
        hilo_rd_sel_s    = 1'b0;
`endif

        // Counter only advances while a stall is in progress.
        if (TIMEOUT_EN && stall_s) begin
            wait_cnt_d = wait_cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_d = {TIMEOUT_W{1'b0}};
        end

        case (state_q)
            ST_FETCH: begin
                ram_rds_s = 1'b1;
                if (timeout_s) begin
                    state_d  = ST_FAULT;
                    fault_d  = 1'b1;
                    active_d = 1'b0;
                end else if (waitrequest_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC1;
                end
            end

            ST_EXEC1: begin
                ir_wen_s    = 1'b1;
                src_b_sel_s = ctrl_s.src_b_sel;
                alu_op_s    = ctrl_s.alu_op;
                a3_sel_s    = ctrl_s.a3_sel;
                wd_sel_s    = ctrl_s.wd_sel;
                if (is_mem_s) begin
                    ram_a_sel_s = 1'b1;
                    src_b_sel_s = SRCB_SEXT;
                    ram_rds_s   = ctrl_s.is_load;
                    ram_wen_s   = ctrl_s.is_store;
                end else begin
                    ram_a_sel_s = 1'b0;
                end
                if (ctrl_s.illegal || timeout_s) begin
                    state_d  = ST_FAULT;
                    fault_d  = 1'b1;
                    active_d = 1'b0;
                end else if (is_mem_s && waitrequest_i) begin
                    state_d = ST_EXEC1;
                end else begin
                    state_d = ST_EXEC2;
                end
            end

            ST_EXEC2: begin
                src_b_sel_s = ctrl_s.src_b_sel;
                alu_op_s    = ctrl_s.alu_op;
                a3_sel_s    = ctrl_s.a3_sel;
                wd_sel_s    = ctrl_s.wd_sel;
`ifdef CPU_CONTROL_MULTDIV_EN
                hilo_rd_sel_s = ctrl_s.hilo_rd_sel;
`endif
                if (mf_stall_s) begin
                    // HI/LO not ready yet: hold everything, including the delay slot.
                    state_d = ST_EXEC2;
                end else begin
                    pc_wen_s  = 1'b1;
                    reg_wen_s = ctrl_s.reg_wen;
`ifdef CPU_CONTROL_MULTDIV_EN
                    md_start_s = ctrl_s.md_start;
                    hilo_wen_s = ctrl_s.hilo_wen;
`endif
                    // The slot instruction commits the previously latched target.
                    if (branch_pending_q) begin
                        pc_sel_s = pend_sel_q;
                    end else begin
                        pc_sel_s = PC_PLUS4;
                    end
                    // A new taken branch (even inside a slot) captures its own target.
                    tgt_wen_s        = taken_s;
                    branch_pending_d = taken_s;
                    if (taken_s) begin
                        pend_sel_d = ctrl_s.is_jump ? PC_JUMP : PC_BRANCH;
                    end else begin
                        pend_sel_d = PC_PLUS4;
                    end
                    if (branch_pending_q && (pend_sel_q == PC_JUMP) && jump_to_zero_i) begin
                        state_d  = ST_HALTED;
                        active_d = 1'b0;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_HALTED: begin
                state_d  = ST_HALTED;
                active_d = 1'b0;
            end

            ST_FAULT: begin
                state_d  = ST_FAULT;
                fault_d  = 1'b1;
                active_d = 1'b0;
            end

            default: begin
                // Unreachable encodings are treated as a fault.
                state_d  = ST_FAULT;
                fault_d  = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    // State, delay-slot, wait-counter and status registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= ST_FETCH;
            branch_pending_q <= 1'b0;
            pend_sel_q       <= PC_PLUS4;
            wait_cnt_q       <= {TIMEOUT_W{1'b0}};
            fault_q          <= 1'b0;
            active_q         <= 1'b1;
        end else begin
            state_q          <= state_d;
            branch_pending_q <= branch_pending_d;
            pend_sel_q       <= pend_sel_d;
            wait_cnt_q       <= wait_cnt_d;
            fault_q          <= fault_d;
            active_q         <= active_d;
        end
    end

    assign state_o      = state_q;
    assign active_o     = active_q;
    assign fault_o      = fault_q;
    assign pc_wen_o     = pc_wen_s;
    assign ir_wen_o     = ir_wen_s;
    assign ram_wen_o    = ram_wen_s;
    assign ram_rds_o    = ram_rds_s;
    assign reg_wen_o    = reg_wen_s;
    assign ram_a_sel_o  = ram_a_sel_s;
    assign src_b_sel_o  = src_b_sel_s;
    assign reg_wd_sel_o = wd_sel_s;
    assign reg_a3_sel_o = a3_sel_s;
    assign pc_sel_o     = pc_sel_s;
    assign tgt_wen_o    = tgt_wen_s;
    assign alu_op_o     = ALU_OP_W'(alu_op_s);
`ifdef CPU_CONTROL_MULTDIV_EN
    assign md_start_o    = md_start_s;
    assign hilo_wen_o    = hilo_wen_s;
    assign hilo_rd_sel_o = hilo_rd_sel_s;
`endif

endmodule

// File: tb/tb_cpu_fsm_control.sv
// ---------------------------------------------------------------------------
// tb_cpu_fsm_control
// Directed bench for cpu_fsm_control: one instance with default parameters
// and one with WAIT_TIMEOUT = 4, sharing all inputs.
// ---------------------------------------------------------------------------
module tb_cpu_fsm_control;

    localparam logic [31:0] S_FETCH  = 32'd0;
    localparam logic [31:0] S_EXEC1  = 32'd1;
    localparam logic [31:0] S_EXEC2  = 32'd2;
    localparam logic [31:0] S_HALTED = 32'd3;
    localparam logic [31:0] S_FAULT  = 32'd4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       waitrequest_i;
    logic [5:0] opcode_i;
    logic [5:0] function_i;
    logic       alu_zero_i;
    logic       jump_to_zero_i;

    logic [2:0] state_o, state_t_o;
    logic       active_o, active_t_o;
    logic       fault_o, fault_t_o;
    logic       pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o, reg_wen_o;
    logic       pc_wen_t, ir_wen_t, ram_wen_t, ram_rds_t, reg_wen_t;
    logic       ram_a_sel_o, ram_a_sel_t;
    logic [1:0] src_b_sel_o, reg_wd_sel_o, reg_a3_sel_o, pc_sel_o;
    logic [1:0] src_b_sel_t, reg_wd_sel_t, reg_a3_sel_t, pc_sel_t;
    logic       tgt_wen_o, tgt_wen_t;
    logic [3:0] alu_op_o, alu_op_t;
`ifdef CPU_CONTROL_MULTDIV_EN
    logic       md_busy_i = 1'b0;
    logic       md_start_o, hilo_wen_o, hilo_rd_sel_o;
    logic       md_start_t, hilo_wen_t, hilo_rd_sel_t;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    cpu_fsm_control dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .waitrequest_i(waitrequest_i),
        .opcode_i(opcode_i), .function_i(function_i),
        .alu_zero_i(alu_zero_i), .jump_to_zero_i(jump_to_zero_i),
`ifdef CPU_CONTROL_MULTDIV_EN
        .md_busy_i(md_busy_i), .md_start_o(md_start_o),
        .hilo_wen_o(hilo_wen_o), .hilo_rd_sel_o(hilo_rd_sel_o),
`endif
        .state_o(state_o), .active_o(active_o), .fault_o(fault_o),
        .pc_wen_o(pc_wen_o), .ir_wen_o(ir_wen_o), .ram_wen_o(ram_wen_o),
        .ram_rds_o(ram_rds_o), .reg_wen_o(reg_wen_o), .ram_a_sel_o(ram_a_sel_o),
        .src_b_sel_o(src_b_sel_o), .reg_wd_sel_o(reg_wd_sel_o),
        .reg_a3_sel_o(reg_a3_sel_o), .pc_sel_o(pc_sel_o),
        .tgt_wen_o(tgt_wen_o), .alu_op_o(alu_op_o)
    );

    cpu_fsm_control #(.WAIT_TIMEOUT(4)) dut_to (
        .clk_i(clk_i), .rst_ni(rst_ni), .waitrequest_i(waitrequest_i),
        .opcode_i(opcode_i), .function_i(function_i),
        .alu_zero_i(alu_zero_i), .jump_to_zero_i(jump_to_zero_i),
`ifdef CPU_CONTROL_MULTDIV_EN
        .md_busy_i(md_busy_i), .md_start_o(md_start_t),
        .hilo_wen_o(hilo_wen_t), .hilo_rd_sel_o(hilo_rd_sel_t),
`endif
        .state_o(state_t_o), .active_o(active_t_o), .fault_o(fault_t_o),
        .pc_wen_o(pc_wen_t), .ir_wen_o(ir_wen_t), .ram_wen_o(ram_wen_t),
        .ram_rds_o(ram_rds_t), .reg_wen_o(reg_wen_t), .ram_a_sel_o(ram_a_sel_t),
        .src_b_sel_o(src_b_sel_t), .reg_wd_sel_o(reg_wd_sel_t),
        .reg_a3_sel_o(reg_a3_sel_t), .pc_sel_o(pc_sel_t),
        .tgt_wen_o(tgt_wen_t), .alu_op_o(alu_op_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] enables();
        return {26'd0, pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o, reg_wen_o, tgt_wen_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni         = 1'b0;
        waitrequest_i  = 1'b0;
        opcode_i       = 6'h09;
        function_i     = 6'h00;
        alu_zero_i     = 1'b0;
        jump_to_zero_i = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_state",  32'(state_o),  S_FETCH);
        chk("rst_active", 32'(active_o), 32'd1);
        chk("rst_fault",  32'(fault_o),  32'd0);
        rst_ni = 1'b1;

        // ADDIU r2,r0,5
        opcode_i = 6'h09;
        #1;
        chk("addiu_f_rds",   32'(ram_rds_o), 32'd1);
        chk("addiu_f_asel",  32'(ram_a_sel_o), 32'd0);
        chk("addiu_f_rwen",  32'(reg_wen_o), 32'd0);
        step();
        chk("addiu_e1_st",   32'(state_o), S_EXEC1);
        chk("addiu_e1_ir",   32'(ir_wen_o), 32'd1);
        chk("addiu_e1_rwen", 32'(reg_wen_o), 32'd0);
        step();
        chk("addiu_e2_st",   32'(state_o), S_EXEC2);
        chk("addiu_e2_rwen", 32'(reg_wen_o), 32'd1);
        chk("addiu_e2_srcb", 32'(src_b_sel_o), 32'd1);
        chk("addiu_e2_a3",   32'(reg_a3_sel_o), 32'd0);
        chk("addiu_e2_pcw",  32'(pc_wen_o), 32'd1);
        chk("addiu_e2_pcs",  32'(pc_sel_o), 32'd0);
        step();
        chk("addiu_back_st", 32'(state_o), S_FETCH);
        chk("addiu_back_rw", 32'(reg_wen_o), 32'd0);

        // LW with 3 FETCH stalls and 2 EXEC1 stalls
        opcode_i = 6'h23;
        for (int i = 0; i < 4; i++) begin
            waitrequest_i = (i < 3);
            #1;
            chk("lw_fetch_st",  32'(state_o), S_FETCH);
            chk("lw_fetch_rds", 32'(ram_rds_o), 32'd1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            waitrequest_i = (i < 2);
            #1;
            chk("lw_e1_st",   32'(state_o), S_EXEC1);
            chk("lw_e1_rds",  32'(ram_rds_o), 32'd1);
            chk("lw_e1_asel", 32'(ram_a_sel_o), 32'd1);
            chk("lw_e1_srcb", 32'(src_b_sel_o), 32'd1);
            step();
        end
        chk("lw_e2_st",   32'(state_o), S_EXEC2);
        chk("lw_e2_rwen", 32'(reg_wen_o), 32'd1);
        chk("lw_e2_wd",   32'(reg_wd_sel_o), 32'd0);
        step();
        chk("lw_back_st", 32'(state_o), S_FETCH);

        // Taken BEQ followed by ADDU in the delay slot
        opcode_i   = 6'h04;
        alu_zero_i = 1'b1;
        step();
        step();
        chk("beq_e2_st",   32'(state_o), S_EXEC2);
        chk("beq_e2_tgt",  32'(tgt_wen_o), 32'd1);
        chk("beq_e2_pcs",  32'(pc_sel_o), 32'd0);
        chk("beq_e2_rwen", 32'(reg_wen_o), 32'd0);
        step();
        opcode_i   = 6'h00;
        function_i = 6'h21;
        alu_zero_i = 1'b0;
        step();
        step();
        #1;
        chk("addu_e2_st",   32'(state_o), S_EXEC2);
        chk("addu_e2_pcs",  32'(pc_sel_o), 32'd1);
        chk("addu_e2_rwen", 32'(reg_wen_o), 32'd1);
        chk("addu_e2_a3",   32'(reg_a3_sel_o), 32'd1);
        chk("addu_e2_tgt",  32'(tgt_wen_o), 32'd0);
        step();

        // Not-taken BNE (alu_zero = 1): no target latch, no redirect afterwards
        opcode_i   = 6'h05;
        alu_zero_i = 1'b1;
        step();
        step();
        chk("bne_nt_tgt", 32'(tgt_wen_o), 32'd0);
        step();
        opcode_i = 6'h09;
        step();
        step();
        chk("bne_nt_slot_pcs", 32'(pc_sel_o), 32'd0);
        step();

        // JR to address 0, then a delay-slot ADDIU: machine halts
        opcode_i       = 6'h00;
        function_i     = 6'h08;
        jump_to_zero_i = 1'b1;
        step();
        step();
        chk("jr_e2_tgt", 32'(tgt_wen_o), 32'd1);
        chk("jr_e2_pcs", 32'(pc_sel_o), 32'd0);
        step();
        chk("jr_no_halt_yet", 32'(state_o), S_FETCH);
        opcode_i = 6'h09;
        step();
        step();
        chk("slot_e2_pcs", 32'(pc_sel_o), 32'd2);
        chk("slot_e2_pcw", 32'(pc_wen_o), 32'd1);
        step();
        chk("halt_st",     32'(state_o), S_HALTED);
        chk("halt_active", 32'(active_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            waitrequest_i = i[0];
            #1;
            chk("halt_en",     enables(), 32'd0);
            chk("halt_st_hold", 32'(state_o), S_HALTED);
            step();
        end
        waitrequest_i  = 1'b0;
        jump_to_zero_i = 1'b0;

        // Reset out of HALTED, then illegal opcode 0x3F
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("rst2_st",     32'(state_o), S_FETCH);
        chk("rst2_active", 32'(active_o), 32'd1);
        opcode_i = 6'h3F;
        step();
        chk("ill_e1_st", 32'(state_o), S_EXEC1);
        step();
        chk("ill_fault_st", 32'(state_o), S_FAULT);
        chk("ill_fault",    32'(fault_o), 32'd1);
        chk("ill_active",   32'(active_o), 32'd0);
        chk("ill_en",       enables(), 32'd0);
        opcode_i = 6'h09;
        step();
        step();
        chk("fault_sticky_st", 32'(state_o), S_FAULT);
        chk("fault_sticky",    32'(fault_o), 32'd1);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("ill_rst_st",    32'(state_o), S_FETCH);
        chk("ill_rst_fault", 32'(fault_o), 32'd0);

        // Wait timeout: 4 stall cycles in FETCH on the WAIT_TIMEOUT=4 instance
        waitrequest_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("to_fetch_st", 32'(state_t_o), S_FETCH);
        end
        step();
        chk("to_fault_st", 32'(state_t_o), S_FAULT);
        chk("to_fault",    32'(fault_t_o), 32'd1);
        chk("nolimit_st",  32'(state_o), S_FETCH);
        chk("nolimit_flt", 32'(fault_o), 32'd0);

        // Reset overrides waitrequest
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("rst_wr_st",    32'(state_t_o), S_FETCH);
        chk("rst_wr_fault", 32'(fault_t_o), 32'd0);
        waitrequest_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
